// File: rtl/t_counter_pkg.sv
// Package for the t_counter slice: direction enum, width limit and bin2gray.
package t_counter_pkg;

`include "t_counter_defs.vh"

    localparam int MAX_WIDTH = `T_COUNTER_MAX_WIDTH;

    typedef enum logic {
        DIR_DOWN_E = `DIR_DOWN,
        DIR_UP_E   = `DIR_UP
    } dir_e;

endpackage

// File: rtl/t_cell.sv
// Single toggle flip-flop: flips its state on every rising edge where t is high.
module t_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    // Toggle storage, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/t_counter_defs.vh
// Shared definitions for the t_counter slice: direction codes, width limit
// and the binary-to-Gray helper.
`ifndef T_COUNTER_DEFS_VH
`define T_COUNTER_DEFS_VH

`define DIR_UP   1'b1
`define DIR_DOWN 1'b0
`define T_COUNTER_MAX_WIDTH 16

// Reflected binary Gray code of a value up to the maximum counter width.
function automatic logic [`T_COUNTER_MAX_WIDTH-1:0] bin2gray(
    input logic [`T_COUNTER_MAX_WIDTH-1:0] b
);
    return b ^ (b >> 1);
endfunction

`endif

// File: rtl/t_counter.sv
// Up/down modulo counter built from a chain of toggle cells.
// The parent works out every cell's T input so that load, modulo wrap and the
// plain binary carry chain all reduce to "flip the bits that must change".
// Optional macro T_COUNTER_GRAY_OUT_EN adds a registered Gray-coded copy q_gray.
module t_counter
    import t_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
`ifdef T_COUNTER_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    dir_e             dir;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] load_eff;
    logic             carry_up;
    logic             carry_dn;

    assign dir = dir_e'(up);

    // Terminal count is purely combinational so a consumer sees it in the
    // same cycle the counter sits on the boundary.
    assign tc = en & ((dir == DIR_UP_E) ? (q == TOP) : (q == '0));

    // Out-of-range loads are clamped so q can never leave 0..MODULUS-1.
    assign load_eff = (load_val <= TOP) ? load_val : TOP;

    // Value the counter jumps to when it wraps in the current direction.
    assign target = (dir == DIR_UP_E) ? '0 : TOP;

    // T-input generation: load and wrap force T = q ^ destination, otherwise
    // the running all-ones / all-zeros chain gives the binary toggle rule.
    always_comb begin
        t        = '0;
        carry_up = 1'b1;
        carry_dn = 1'b1;
        if (load) begin
            t = q ^ load_eff;
        end else if (tc) begin
            t = q ^ target;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                t[i]     = (dir == DIR_UP_E) ? carry_up : carry_dn;
                carry_up = carry_up & q[i];
                carry_dn = carry_dn & ~q[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_cell
            t_cell u_cell (
                .clk (clk),
                .rst (rst),
                .t   (t[g]),
                .q   (q[g])
            );
        end
    endgenerate

    // Wrap pulse and sticky overflow; a set in the same cycle beats ovf_clr,
    // and a load cycle neither pulses wrap nor touches ovf.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            wrap <= tc & ~load;
            if (tc & ~load) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef T_COUNTER_GRAY_OUT_EN
    logic [WIDTH-1:0] q_next;

    assign q_next = q ^ t;

    // Gray copy is registered from the next binary value so it lines up with q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_gray <= '0;
        end else begin
            q_gray <= WIDTH'(bin2gray(MAX_WIDTH'(q_next)));
        end
    end
`endif

endmodule

// File: tb/tb_t_counter.sv
// Scoreboard bench for t_counter (WIDTH=4, MODULUS=10). Each stimulus row
// pushes the outputs expected during that cycle; a negedge monitor pops and
// compares. With T_COUNTER_GRAY_OUT_EN a second MODULUS=16 instance is checked.
module tb_t_counter;

    typedef struct {
        logic [3:0] q;
        logic       tc;
        logic       wrap;
        logic       ovf;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       ovf_clr = 1'b0;
    logic [3:0] q;
    logic       tc;
    logic       wrap;
    logic       ovf;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

`ifdef T_COUNTER_GRAY_OUT_EN
    logic [3:0] q_gray;
`endif

    t_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .ovf_clr  (ovf_clr),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap),
        .ovf      (ovf)
`ifdef T_COUNTER_GRAY_OUT_EN
        ,
        .q_gray   (q_gray)
`endif
    );

`ifdef T_COUNTER_GRAY_OUT_EN
    typedef struct {
        logic [3:0] gray;
        logic       adj;
    } gexp_t;

    logic       g_rst = 1'b1;
    logic       g_en = 1'b0;
    logic [3:0] g_q;
    logic       g_tc;
    logic       g_wrap;
    logic       g_ovf;
    logic [3:0] g_gray;
    logic [3:0] g_prev = 4'd0;
    gexp_t      gq[$];

    t_counter #(.WIDTH(4), .MODULUS(16)) dut_gray (
        .clk      (clk),
        .rst      (g_rst),
        .en       (g_en),
        .up       (1'b1),
        .load     (1'b0),
        .load_val (4'd0),
        .ovf_clr  (1'b0),
        .q        (g_q),
        .tc       (g_tc),
        .wrap     (g_wrap),
        .ovf      (g_ovf),
        .q_gray   (g_gray)
    );
`endif

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: drive just after the rising edge, record what the
    // outputs must read before the next rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic u, input logic l,
                                 input logic [3:0] lv, input logic c,
                                 input logic [3:0] eq, input logic etc, input logic ew,
                                 input logic eo, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst      = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv;
        ovf_clr  = c;
        x.q    = eq;
        x.tc   = etc;
        x.wrap = ew;
        x.ovf  = eo;
        x.name = nm;
        sbq.push_back(x);
    endtask

    // Monitor: compares every pending expectation at the falling edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t x;
            x = sbq.pop_front();
            checkOutput({x.name, ".q"},    16'(q),    16'(x.q));
            checkOutput({x.name, ".tc"},   16'(tc),   16'(x.tc));
            checkOutput({x.name, ".wrap"}, 16'(wrap), 16'(x.wrap));
            checkOutput({x.name, ".ovf"},  16'(ovf),  16'(x.ovf));
`ifdef T_COUNTER_GRAY_OUT_EN
            checkOutput({x.name, ".q_gray"}, 16'(q_gray), 16'(x.q ^ (x.q >> 1)));
`endif
        end
`ifdef T_COUNTER_GRAY_OUT_EN
        if (gq.size() > 0) begin
            gexp_t gx;
            gx = gq.pop_front();
            checkOutput("gray.value", 16'(g_gray), 16'(gx.gray));
            if (gx.adj) begin
                checkOutput("gray.onebit", 16'($countones(g_gray ^ g_prev)), 16'd1);
            end
            g_prev <= g_gray;
        end
`endif
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //            r  e  u  l  lv  c    q  tc w  o   name
        applyStimulus(1, 0, 0, 0, 0,  0,   0, 0, 0, 0, "reset");
        // Count up through the MODULUS=10 wrap
        applyStimulus(0, 1, 1, 0, 0,  0,   0, 0, 0, 0, "up0");
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 1, 1, 0, 0, 0, 4'(k), 0, 0, 0, $sformatf("up%0d", k));
        end
        applyStimulus(0, 1, 1, 0, 0,  0,   9, 1, 0, 0, "up9_tc");
        applyStimulus(0, 1, 1, 0, 0,  0,   0, 0, 1, 1, "up_wrap");
        applyStimulus(0, 1, 1, 0, 0,  0,   1, 0, 0, 1, "up_after");
        // Load 1 then count down across zero
        applyStimulus(0, 1, 0, 1, 1,  0,   2, 0, 0, 1, "dn_load1");
        applyStimulus(0, 1, 0, 0, 0,  0,   1, 0, 0, 1, "dn1");
        applyStimulus(0, 1, 0, 0, 0,  0,   0, 1, 0, 1, "dn0_tc");
        applyStimulus(0, 1, 0, 0, 0,  0,   9, 0, 1, 1, "dn_wrap");
        applyStimulus(0, 0, 0, 0, 0,  0,   8, 0, 0, 1, "hold");
        // Clamp and load priority over a terminal count
        applyStimulus(0, 1, 1, 1, 13, 0,   8, 0, 0, 1, "clamp13");
        applyStimulus(0, 1, 1, 1, 3,  0,   9, 1, 0, 1, "load_at_tc");
        applyStimulus(0, 0, 0, 0, 0,  0,   3, 0, 0, 1, "load_nowrap");
        applyStimulus(0, 0, 0, 0, 0,  1,   3, 0, 0, 1, "clr");
        applyStimulus(0, 1, 1, 1, 15, 0,   3, 0, 0, 0, "clamp15");
        applyStimulus(0, 1, 1, 1, 0,  0,   9, 1, 0, 0, "load_tc_noovf");
        applyStimulus(0, 0, 0, 0, 0,  0,   0, 0, 0, 0, "load_kept_ovf0");
        // Set beats clear in the same cycle, clear alone works afterwards
        applyStimulus(0, 1, 0, 0, 0,  1,   0, 1, 0, 0, "race");
        applyStimulus(0, 0, 0, 0, 0,  1,   9, 0, 1, 1, "race_setwins");
        applyStimulus(0, 0, 0, 0, 0,  0,   9, 0, 0, 0, "race_cleared");
        // Async reset while q, wrap and ovf are all non-zero
        applyStimulus(0, 0, 0, 1, 0,  0,   9, 0, 0, 0, "pre_load0");
        applyStimulus(0, 1, 0, 0, 0,  0,   0, 1, 0, 0, "pre_wrap");
        applyStimulus(1, 1, 1, 0, 0,  0,   0, 0, 0, 0, "async_rst");
        applyStimulus(0, 1, 1, 0, 0,  0,   0, 0, 0, 0, "resume0");
        applyStimulus(0, 1, 1, 0, 0,  0,   1, 0, 0, 0, "resume1");
        applyStimulus(0, 0, 1, 0, 0,  0,   2, 0, 0, 0, "resume2");

`ifdef T_COUNTER_GRAY_OUT_EN
        begin
            logic [3:0] gtab [0:16];
            gexp_t gx;
            gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                     4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
            @(posedge clk);
            #1;
            g_rst = 1'b1;
            gx.gray = 4'h0;
            gx.adj  = 1'b0;
            gq.push_back(gx);
            for (int k = 0; k <= 16; k++) begin
                @(posedge clk);
                #1;
                g_rst = 1'b0;
                g_en  = 1'b1;
                gx.gray = gtab[k];
                gx.adj  = (k > 0);
                gq.push_back(gx);
            end
        end
`endif

        repeat (3) @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
